// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared types, constants and the round-robin pick helper for the
// four-client arbiter.
//   state_t     : arbiter FSM states (IDLE, GRANT)
//   NUM_CLIENTS : number of requesters
//   IDX_W       : width of a client index
//   rr_pick     : rotate-and-find-first-set winner selection
package rr_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int NUM_CLIENTS = 4;
  localparam int IDX_W       = 2;

  // Search last+1, last+2, last+3, last (mod 4) and return the first set bit.
  // The index arithmetic wraps naturally in IDX_W bits. With no request the
  // pointer itself is returned so the result is never undefined.
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [NUM_CLIENTS-1:0] req,
    input logic [IDX_W-1:0]       last
  );
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] pick;
    logic             found;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= NUM_CLIENTS; i++) begin
      idx = last + IDX_W'(i);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: combinational round-robin winner selection.
//   req     in  [3:0] per-client request
//   last    in  [1:0] most recently granted client (lowest priority)
//   winner  out [1:0] selected client; equals last when no request is set
//   any_req out       at least one request is set
module rr_priority_pick
  import rr_arb_pkg::*;
(
  input  logic [NUM_CLIENTS-1:0] req,
  input  logic [IDX_W-1:0]       last,
  output logic [IDX_W-1:0]       winner,
  output logic                   any_req
);

  // Rotating priority search starting just after the previous grantee.
  always_comb begin
    winner  = rr_pick(req, last);
    any_req = |req;
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: four-client round-robin arbiter with grant hold and watchdog.
//   clk       in      system clock, rising edge
//   rst       in      asynchronous active-high reset
//   req       in  [3:0] level-sensitive per-client request
//   done      in      grantee completion, only looked at while granted
//   gnt_valid out     registered, high while a grant is active
//   gnt_idx   out [1:0] registered index of the granted client (qualify with gnt_valid)
//   timeout   out     registered one-cycle pulse on a watchdog-forced release
module rr_arbiter_4
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CLIENTS-1:0] req,
  input  logic                   done,
  output logic                   gnt_valid,
  output logic [IDX_W-1:0]       gnt_idx,
  output logic                   timeout
);

  localparam int             CNT_W     = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};

  state_t           state_r;
  logic [IDX_W-1:0] last_r;
  logic [CNT_W-1:0] hold_cnt_r;
  logic [IDX_W-1:0] winner_s;
  logic             any_req_s;

  rr_priority_pick u_pick (
    .req     (req),
    .last    (last_r),
    .winner  (winner_s),
    .any_req (any_req_s)
  );

  // Arbiter FSM: grant selection, release priority, hold counter and outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      gnt_valid  <= 1'b0;
      gnt_idx    <= 2'b00;
      timeout    <= 1'b0;
      hold_cnt_r <= '0;
      last_r     <= 2'd3;
    end else begin
      timeout <= 1'b0;
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            state_r    <= GRANT;
            gnt_valid  <= 1'b1;
            gnt_idx    <= winner_s;
            last_r     <= winner_s;
            hold_cnt_r <= '0;
          end else begin
            state_r   <= IDLE;
            gnt_valid <= 1'b0;
          end
        end
        GRANT: begin
          // done outranks the watchdog, so a coincident done never pulses timeout.
          if (done || !req[gnt_idx]) begin
            state_r    <= IDLE;
            gnt_valid  <= 1'b0;
            hold_cnt_r <= '0;
          end else if (hold_cnt_r == HOLD_LAST) begin
            state_r    <= IDLE;
            gnt_valid  <= 1'b0;
            hold_cnt_r <= '0;
            timeout    <= 1'b1;
          end else begin
            if (hold_cnt_r != CNT_SAT) begin
              hold_cnt_r <= hold_cnt_r + CNT_W'(1);
            end else begin
              hold_cnt_r <= hold_cnt_r;
            end
          end
        end
        default: begin
          state_r   <= IDLE;
          gnt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter_4.sv
// tb_rr_arbiter_4: directed self-checking bench for rr_arbiter_4 (MAX_HOLD=16).
module tb_rr_arbiter_4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic       gnt_valid;
  logic [1:0] gnt_idx;
  logic       timeout;

  int tests_run;
  int tests_failed;

  rr_arbiter_4 #(.MAX_HOLD(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .timeout   (timeout)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = 4'b0000;
    done = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Global bound in case the run ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got 0 expected 1 (bench time limit reached)");
    $fatal(1, "bench time limit");
  end

  initial begin
    int exp_seq [5];
    int hold_len;
    tests_run    = 0;
    tests_failed = 0;
    exp_seq = '{0, 1, 2, 3, 0};

    // Reset state.
    do_reset();
    check("rst_valid", int'(gnt_valid), 0);
    check("rst_idx", int'(gnt_idx), 0);
    check("rst_timeout", int'(timeout), 0);

    // done while idle is ignored.
    done = 1'b1;
    step();
    check("idle_done_valid", int'(gnt_valid), 0);
    done = 1'b0;

    // 1: single requester, release on done.
    req = 4'b0001;
    step();
    check("t1_grant_valid", int'(gnt_valid), 1);
    check("t1_grant_idx", int'(gnt_idx), 0);
    step();
    check("t1_hold_valid", int'(gnt_valid), 1);
    done = 1'b1;
    step();
    check("t1_release_valid", int'(gnt_valid), 0);
    check("t1_release_timeout", int'(timeout), 0);
    done = 1'b0;
    req  = 4'b0000;
    step();
    check("t1_idle_idx_held", int'(gnt_idx), 0);

    // 2: all requesting, order 0,1,2,3,0 with one idle cycle between grants.
    do_reset();
    req = 4'b1111;
    foreach (exp_seq[k]) begin
      step();
      check($sformatf("t2_valid_%0d", k), int'(gnt_valid), 1);
      check($sformatf("t2_idx_%0d", k), int'(gnt_idx), exp_seq[k]);
      step();
      check($sformatf("t2_hold_%0d", k), int'(gnt_valid), 1);
      done = 1'b1;
      step();
      check($sformatf("t2_gap_%0d", k), int'(gnt_valid), 0);
      done = 1'b0;
    end
    req = 4'b0000;
    step();

    // 3: watchdog forced release after exactly 16 valid cycles.
    req = 4'b0100;
    step();
    check("t3_idx", int'(gnt_idx), 2);
    hold_len = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (!gnt_valid) break;
      hold_len++;
    end
    check("t3_hold_len", hold_len, 16);
    check("t3_timeout_pulse", int'(timeout), 1);
    step();
    check("t3_regrant_valid", int'(gnt_valid), 1);
    check("t3_regrant_idx", int'(gnt_idx), 2);
    check("t3_timeout_clear", int'(timeout), 0);
    req = 4'b0000;
    step();
    check("t3_drop_valid", int'(gnt_valid), 0);
    check("t3_drop_timeout", int'(timeout), 0);

    // 4: client 1 drops its request, client 3 served after the idle cycle.
    req = 4'b0010;
    step();
    check("t4_idx1", int'(gnt_idx), 1);
    check("t4_valid1", int'(gnt_valid), 1);
    req = 4'b1000;
    step();
    check("t4_release", int'(gnt_valid), 0);
    check("t4_timeout", int'(timeout), 0);
    step();
    check("t4_valid3", int'(gnt_valid), 1);
    check("t4_idx3", int'(gnt_idx), 3);
    req = 4'b0000;
    step();

    // 5: done coincides with the last permitted hold cycle.
    req = 4'b0001;
    step();
    check("t5_idx", int'(gnt_idx), 0);
    for (int i = 0; i < 15; i++) step();
    check("t5_still_valid", int'(gnt_valid), 1);
    done = 1'b1;
    step();
    check("t5_release", int'(gnt_valid), 0);
    check("t5_no_timeout", int'(timeout), 0);
    done = 1'b0;
    req  = 4'b0000;
    step();
    check("t5_no_timeout_after", int'(timeout), 0);

    // 6: asynchronous reset in the middle of a grant to client 2.
    req = 4'b0100;
    step();
    check("t6_idx2", int'(gnt_idx), 2);
    step();
    #1;
    rst = 1'b1;
    #1;
    check("t6_async_valid", int'(gnt_valid), 0);
    check("t6_async_idx", int'(gnt_idx), 0);
    req = 4'b1111;
    step();
    rst = 1'b0;
    step();
    check("t6_post_valid", int'(gnt_valid), 1);
    check("t6_post_idx", int'(gnt_idx), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
